// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   RV32 data-side memory behind the MEM stage. Byte/half/word loads and
//   stores through a valid/ready request channel and a valid/ready response
//   channel. The response arrives LATENCY cycles after acceptance. Loads are
//   sign- or zero-extended. Misaligned, out-of-range and illegal-size
//   accesses report resp_err and never touch the array.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_W       byte address width
//   LATENCY      cycles from acceptance to resp_valid (>= 1)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend sub-word loads when 1
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data (0 for stores and faults)
//   resp_err          access faulted
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Storage and registered state
    logic [31:0]      mem [DEPTH_WORDS];
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             req_ready_q,  req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q,   resp_err_d;

    // Request decode
    logic             accept;
    logic             fault;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes;
    logic             mem_we;

    assign accept   = req_valid && req_ready_q;
    assign word_idx = req_addr[IDX_W+1:2];
    assign lane     = req_addr[1:0];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign rd_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    // Any address bit at or above log2(4*DEPTH_WORDS) puts the access out of range.
    always_comb begin
        fault = 1'b0;
        if ((req_addr >> (IDX_W + 2)) != '0) fault = 1'b1;
        case (req_size)
            2'b01:   if (req_addr[0])         fault = 1'b1;
            2'b10:   if (req_addr[1:0] != 0)  fault = 1'b1;
            2'b11:                            fault = 1'b1;
            default: ;
        endcase
    end

    // Load extraction and store lane steering
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        load_data   = rd_word;
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
        case (req_size)
            2'b00: begin
                load_data   = req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                load_data   = req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // A request coinciding with reset is never accepted, so it must not write.
    assign mem_we = accept && !fault && req_we && !rst;

    // NOTE: the array has no reset; resetting a RAM would turn it into
    // thousands of flops, and software never relies on its initial contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready_d  = 1'b0;
                    resp_err_d   = fault;
                    resp_rdata_d = (fault || req_we) ? 32'd0 : load_data;
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                // Counter holds the number of cycles still to wait before RESP.
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = S_RESP;
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Two instances: index 0 has LATENCY=1, index 1 has LATENCY=4 (both 1024
//   words). A directed table, hand-written reset sequences and random
//   traffic are checked against a byte-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference memory: plain byte array per instance, little-endian.
    logic [7:0] mm [2][4*DEPTH];

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Behavioural reference: fault rules, then byte-wise store or load.
    task automatic model_ref(input int d, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic err);
        int nb;
        logic [31:0] val;
        nb  = 1 << size;
        err = (size == 2'd3) || (addr >= 32'(4 * DEPTH)) || (addr % nb != 0);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mm[d][addr + i] = wdata[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < nb; i++) val = val | (32'(mm[d][addr + i]) << (8 * i));
                if (!uns && nb < 4 && val[8*nb - 1]) val = val | ~((32'd1 << (8 * nb)) - 32'd1);
                rd = val;
            end
        end
    endtask

    task automatic do_txn(input int d, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int hold, input string tag);
        int edges;
        logic bad;
        logic [31:0] held_rd;
        logic held_err;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(req_ready[d]), 32'd1);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        @(posedge clk);
        #1;
        // Scramble the request fields: they must not matter after acceptance.
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom);
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_addr[d]     = $urandom;
        req_wdata[d]    = $urandom;
        edges = 1;
        bad   = 1'b0;
        while (!resp_valid[d] && edges < 40) begin
            if (req_ready[d]) bad = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(lat_of(d)));
        check({tag, " rdata"}, resp_rdata[d], exp_rd);
        check({tag, " err"}, 32'(resp_err[d]), 32'(exp_err));
        held_rd  = resp_rdata[d];
        held_err = resp_err[d];
        for (int i = 0; i < hold; i++) begin
            if (req_ready[d]) bad = 1'b1;
            @(posedge clk);
            #1;
            if (!resp_valid[d] || resp_rdata[d] !== held_rd || resp_err[d] !== held_err || req_ready[d])
                bad = 1'b1;
        end
        check({tag, " busy/hold violation"}, 32'(bad), 32'd0);
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        check({tag, " post-handshake {valid,ready,err}"},
              {29'd0, resp_valid[d], req_ready[d], resp_err[d]}, 32'b010);
        check({tag, " post-handshake rdata"}, resp_rdata[d], 32'd0);
    endtask

    // Model-driven transaction
    task automatic txn_m(input int d, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input string tag);
        logic [31:0] rd;
        logic err;
        model_ref(d, we, size, uns, addr, wdata, rd, err);
        do_txn(d, we, size, uns, addr, wdata, rd, err, hold, tag);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] rd_dummy;
        logic err_dummy;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'hFFFFFF5A, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD5AEF, 1'b0};
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h20,   32'h0,        32'h0,        1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b1, 32'h22,   32'h12348001, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h22,   32'h0,        32'hFFFF8001, 1'b0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h22,   32'h0,        32'h00008001, 1'b0};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        32'h80010000, 1'b0};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h13,   32'hCAFEF00D, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b1};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 32'h10,   32'hCAFEF00D, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};
        tbl[15] = '{1'b0, 2'd1, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1};
        tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD5AEF, 1'b0};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dut%0d {valid,ready,err}", d),
                  {29'd0, resp_valid[d], req_ready[d], resp_err[d]}, 32'b010);
            check($sformatf("reset dut%0d rdata", d), resp_rdata[d], 32'd0);
        end

        // Give a known value to the region used by the rest of the run.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++)
                txn_m(d, 1'b1, 2'd2, 1'b0, 32'(4 * w), 32'd0, 0, $sformatf("init d%0d w%0d", d, w));

        // Directed table on the LATENCY=1 instance
        for (int i = 0; i < 17; i++) begin
            model_ref(0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                      rd_dummy, err_dummy);
            do_txn(0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                   tbl[i].exp_rd, tbl[i].exp_err, i % 2, $sformatf("tbl[%0d]", i));
        end

        // LATENCY=4 with the consumer stalling three extra cycles
        do_txn(1, 1'b1, 2'd2, 1'b0, 32'h08, 32'hA5A55A5A, 32'h0, 1'b0, 0, "l4 store");
        model_ref(1, 1'b1, 2'd2, 1'b0, 32'h08, 32'hA5A55A5A, rd_dummy, err_dummy);
        do_txn(1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'hA5A55A5A, 1'b0, 3, "l4 load stall");

        // Reset while in WAIT: the store committed at acceptance survives.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h40; req_wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        check("wait before rst resp_valid", 32'(resp_valid[1]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst in WAIT {valid,ready,err}",
              {29'd0, resp_valid[1], req_ready[1], resp_err[1]}, 32'b010);
        check("rst in WAIT rdata", resp_rdata[1], 32'd0);
        model_ref(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, rd_dummy, err_dummy);
        do_txn(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, 0, "load after rst");

        // A request presented together with rst is not accepted.
        @(negedge clk);
        rst = 1'b1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
        req_addr[1] = 32'h44; req_wdata[1] = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid[1] = 1'b0;
        check("req with rst {valid,ready}", {30'd0, resp_valid[1], req_ready[1]}, 32'b01);
        txn_m(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 0, "load after rejected store");

        // Random traffic against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                int r;
                int s;
                logic [1:0] size;
                logic [31:0] addr;
                r = $urandom_range(0, 9);
                if (r < 8)       addr = 32'($urandom_range(0, 127));
                else if (r == 8) addr = 32'(4096 + $urandom_range(0, 4095));
                else             addr = $urandom | 32'h8000_0000;
                s = $urandom_range(0, 9);
                size = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
                txn_m(d, 1'($urandom), size, 1'($urandom), addr, $urandom,
                      $urandom_range(0, 2), $sformatf("rand d%0d #%0d", d, n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised RV32 data memory with a valid/ready request/response handshake and configurable read/write latency. Supports byte, halfword and word accesses with byte lanes, sign/zero extension on loads, and fault reporting for misaligned and out-of-range addresses. Sits behind the MEM stage as the core's data-side memory. It replaces the single-cycle combinational-read word memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, at least 4.
ADDR_W, 32, width of the byte address.
LATENCY, 1, cycles from request acceptance to resp_valid; at least 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored for word accesses and stores.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned; the low 8 or 16 bits are used for byte and half stores.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  32  extended load data; 0 for stores and faults.
resp_err  out  1  access faulted.

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- A request is accepted on a rising edge where req_valid and req_ready are both 1. req_ready=1 only in IDLE.
- At the acceptance edge:
  - The fault check is evaluated.
  - Load data is sampled from the array, so it reflects all earlier committed stores.
  - A non-faulting store commits to the array. Only the addressed byte lanes are written: byte → lane addr[1:0]; half → lanes {addr[1],0} and {addr[1],1}.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Faults (resp_err=1, no array write, resp_rdata=0):
  - misaligned: half with addr[0]=1, or word with addr[1:0]≠0;
  - out of range: addr ≥ 4*DEPTH_WORDS;
  - req_size=11.
- Load extraction: select the byte or half by addr[1:0]/addr[1]. Sign-extend from bit 7 or 15 unless req_unsigned=1.
- Sequencing after acceptance:
  - LATENCY=1: go directly to RESP; resp_valid=1 on the next cycle.
  - LATENCY>1: go to WAIT with counter=LATENCY-1; decrement each cycle; enter RESP when the counter reaches 1.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until a resp_ready handshake.
  - On the handshake edge, return to IDLE: resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready rises the cycle after the handshake. There is no same-cycle back-to-back request, so maximum throughput is one access per LATENCY+1 cycles.
- rst asserted in any state aborts the transaction and restores the reset values.
  - A store already committed at its acceptance edge remains in the array.
  - A request presented in the same cycle as rst is not accepted.
- Request inputs are sampled only at acceptance. Later changes to them have no effect.

Test Plan:
- Reset, then store word 0xDEADBEEF @0x10 and load word @0x10 (LATENCY=1) → req_ready=1 after reset; each resp_valid one cycle after acceptance; load resp_rdata=0xDEADBEEF, resp_err=0.
- After the previous step, store byte 0x5A @0x11, then load byte signed @0x13, byte unsigned @0x13, word @0x10 → 0xFFFFFFDE, 0x000000DE, 0xDEAD5AEF.
- Store half 0x8001 @0x22 over word 0; load half signed @0x22 → 0xFFFF8001; load half unsigned @0x22 → 0x00008001; load word @0x20 → 0x80010000.
- Store word @0x13 (misaligned), store @0x1000 with DEPTH_WORDS=1024 (out of range), and a req_size=11 request → resp_err=1 and resp_rdata=0 for each; a following load shows the array unchanged.
- LATENCY=4, with resp_ready held low 3 extra cycles → resp_valid rises exactly 4 cycles after acceptance; data held stable until the handshake; req_ready=0 throughout and returns to 1 the cycle after the handshake.
- rst pulsed while in WAIT (LATENCY=4) during a store of 0x12345678 @0x40 → next cycle IDLE with resp_valid=0 and req_ready=1; a following load @0x40 returns 0x12345678.
